// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx : 8N1 UART receiver with back-pressured output storage.           |
// | UART_RX_FIFO_EN defined selects a 4-entry FIFO, else one holding register. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_rx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] c_full_m1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] c_half_m1 = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_idx;
   logic [7:0]      r_shift;
   logic            r_push;
   logic            r_frame_err;
   logic            r_overrun;
   logic            r_rx_meta;
   logic            r_rx_s;
   logic            w_pop;

   // Synchronizer resets to the idle line level so reset never fakes a start bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!r_rx_s) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
               end
            end
            S_START: begin
               if (r_cnt == c_half_m1) begin
                  r_cnt <= '0;
                  r_idx <= '0;
                  r_state <= r_rx_s ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == c_full_m1) begin
                  r_cnt   <= '0;
                  r_shift <= {r_rx_s, r_shift[7:1]};
                  r_idx   <= r_idx + 1'b1;
                  if (r_idx == 3'd7) r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (r_cnt == c_full_m1) begin
                  r_cnt <= '0;
                  if (r_rx_s) begin
                     r_push  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_BREAK: begin
               if (r_rx_s) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // r_shift is stable while r_push is high: shifting only happens in DATA.
`ifdef UART_RX_FIFO_EN
   logic [7:0] r_mem [0:3];
   logic [1:0] r_rd;
   logic [1:0] r_wr;
   logic [2:0] r_count;
   logic       w_full;
   logic       w_push_ok;

   assign w_full    = (r_count == 3'd4);
   assign w_pop     = (r_count != 3'd0) && ready;
   assign w_push_ok = r_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) r_mem[i] <= '0;
         r_rd      <= '0;
         r_wr      <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr] <= r_shift;
            r_wr        <= r_wr + 2'd1;
         end
         if (w_pop) r_rd <= r_rd + 2'd1;
         r_count <= r_count + {2'b00, w_push_ok} - {2'b00, w_pop};
         if (r_push && !w_push_ok) r_overrun <= 1'b1;
      end
   end

   assign data  = r_mem[r_rd];
   assign valid = (r_count != 3'd0);
`else
   logic [7:0] r_hold;
   logic       r_hold_valid;

   assign w_pop = r_hold_valid && ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (r_push && (!r_hold_valid || w_pop)) begin
            r_hold       <= r_shift;
            r_hold_valid <= 1'b1;
         end else if (w_pop) begin
            r_hold_valid <= 1'b0;
         end
         if (r_push && r_hold_valid && !w_pop) r_overrun <= 1'b1;
      end
   end

   assign data  = r_hold;
   assign valid = r_hold_valid;
`endif

   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
